// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module      : systolic_feeder
// Description : Transmit-side driver for an N x N output-stationary PE array.
//               Buffers one A tile and one B tile (row-major load beats).
//               On start it clears the array for one cycle. It then streams
//               skewed, zero-padded operands onto the west edge (A rows) and
//               the north edge (B columns). After a drain window it pulses
//               done.
// Ports       : clk, rst_n        - clock, synchronous active-low reset
//               in_valid/in_ready - tile load handshake
//               in_a, in_b        - A / B element of the current load beat
//               start             - begin streaming the loaded tile
//               west_data         - slice i drives PE row i
//               north_data        - slice j drives PE column j
//               arr_rst_n         - synchronous active-low PE array clear
//               busy, done        - activity flag, one-cycle completion pulse
// Options     : FEEDER_HOLD_TILE_EN - keep the tile after done for replay and
//               allow a new load to start from ARMED
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_feeder #(
  parameter int BIT_WIDTH = 16,
  parameter int N         = 4,
  parameter int DRAIN_CYC = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BIT_WIDTH-1:0]   in_a,
  input  logic [BIT_WIDTH-1:0]   in_b,
  input  logic                   start,
  output logic [N*BIT_WIDTH-1:0] west_data,
  output logic [N*BIT_WIDTH-1:0] north_data,
  output logic                   arr_rst_n,
  output logic                   busy,
  output logic                   done
);

  localparam int NN         = N * N;
  localparam int BEAT_W     = (NN > 1) ? $clog2(NN) : 1;
  localparam int STREAM_LEN = 3 * N - 2;
  localparam int CNT_MAX    = (STREAM_LEN > DRAIN_CYC) ? STREAM_LEN : DRAIN_CYC;
  localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [BEAT_W-1:0] BEAT_LAST   = BEAT_W'(NN - 1);
  localparam logic [CNT_W-1:0]  STREAM_LAST = CNT_W'(STREAM_LEN - 1);
  localparam logic [CNT_W-1:0]  DRAIN_LAST  = CNT_W'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_ARMED  = 3'd1,
    S_CLEAR  = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [N*BIT_WIDTH-1:0] west_q, west_d;
  logic [N*BIT_WIDTH-1:0] north_q, north_d;
  logic                   arr_rst_n_q, arr_rst_n_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   in_ready_q, in_ready_d;
  logic                   accept;

  // Tile storage, row-major: element [r][c] lives at index r*N+c.
  logic [BIT_WIDTH-1:0] a_q [NN];
  logic [BIT_WIDTH-1:0] b_q [NN];

`ifdef FEEDER_HOLD_TILE_EN
  // A start in ARMED takes priority over a load beat offered in the same cycle.
  assign in_ready = in_ready_q & ~((state_q == S_ARMED) & start);
`else
  assign in_ready = in_ready_q;
`endif

  assign accept     = in_valid & in_ready;
  assign west_data  = west_q;
  assign north_data = north_q;
  assign arr_rst_n  = arr_rst_n_q;
  assign busy       = busy_q;
  assign done       = done_q;

  // Next state and counters.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_LOAD: begin
        if (accept) begin
          if (beat_q == BEAT_LAST) begin
            beat_d  = '0;
            state_d = S_ARMED;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_ARMED: begin
        if (start) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end else if (accept) begin
          // Only reachable with tile hold enabled: this is beat 0 of a new tile.
          if (beat_q == BEAT_LAST) begin
            beat_d = '0;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_CLEAR: begin
        state_d = S_STREAM;
        cnt_d   = '0;
      end
      S_STREAM: begin
        if (cnt_q == STREAM_LAST) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        beat_d = '0;
`ifdef FEEDER_HOLD_TILE_EN
        state_d = S_ARMED;
`else
        state_d = S_LOAD;
`endif
      end
      default: begin
        state_d = S_LOAD;
        beat_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // state_q while still taking their reset values during reset.
  always_comb begin
    arr_rst_n_d = (state_d != S_CLEAR);
    busy_d      = (state_d == S_CLEAR) || (state_d == S_STREAM) || (state_d == S_DRAIN);
    done_d      = (state_d == S_DONE);
`ifdef FEEDER_HOLD_TILE_EN
    in_ready_d  = (state_d == S_LOAD) || (state_d == S_ARMED);
`else
    in_ready_d  = (state_d == S_LOAD);
`endif
  end

  // Skewed edge operands for the upcoming stream beat t = cnt_d.
  // Row i sees A[i][t-i]; column j sees B[t-j][j]; zero outside the window.
  always_comb begin
    int t;
    west_d  = '0;
    north_d = '0;
    t       = int'(cnt_d);
    if (state_d == S_STREAM) begin
      for (int i = 0; i < N; i++) begin
        if ((t >= i) && (t - i < N)) begin
          west_d[i*BIT_WIDTH +: BIT_WIDTH]  = a_q[BEAT_W'(i * N + (t - i))];
          north_d[i*BIT_WIDTH +: BIT_WIDTH] = b_q[BEAT_W'((t - i) * N + i)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      beat_q      <= '0;
      cnt_q       <= '0;
      west_q      <= '0;
      north_q     <= '0;
      arr_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      cnt_q       <= cnt_d;
      west_q      <= west_d;
      north_q     <= north_d;
      arr_rst_n_q <= arr_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Tile storage has no reset; a reset only abandons the load in progress.
  always_ff @(posedge clk) begin
    if (accept && rst_n) begin
      a_q[beat_q] <= in_a;
      b_q[beat_q] <= in_b;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_feeder
// Description : Directed self-checking bench for systolic_feeder (default
//               build). It includes a behavioural 4x4 Q8.8 output-stationary
//               PE array fed from the feeder edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        start;
  logic [63:0] west_data;
  logic [63:0] north_data;
  logic        arr_rst_n;
  logic        busy;
  logic        done;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] ma [16];
  logic [15:0] mb [16];
  logic [63:0] cap_w [10];
  logic [63:0] cap_n [10];

  always #5 clk = ~clk;

  systolic_feeder #(.BIT_WIDTH(16), .N(4), .DRAIN_CYC(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .start      (start),
    .west_data  (west_data),
    .north_data (north_data),
    .arr_rst_n  (arr_rst_n),
    .busy       (busy),
    .done       (done)
  );

  // Behavioural PE array: operands move east/south one PE per cycle.
  logic signed [15:0] a_in [4][4];
  logic signed [15:0] b_in [4][4];
  logic signed [15:0] pa [4][4];
  logic signed [15:0] pb [4][4];
  logic signed [31:0] acc [4][4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a_in[i][0] = west_data[i*16 +: 16];
      b_in[0][i] = north_data[i*16 +: 16];
      for (int j = 1; j < 4; j++) begin
        a_in[i][j] = pa[i][j-1];
        b_in[j][i] = pb[j-1][i];
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        pa[i][j] <= arr_rst_n ? a_in[i][j] : 16'sd0;
        pb[i][j] <= arr_rst_n ? b_in[i][j] : 16'sd0;
        acc[i][j] <= arr_rst_n ?
          acc[i][j] + ((32'(a_in[i][j]) * 32'(b_in[i][j])) >>> 8) : 32'sd0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] exp_w(int t);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (t - i >= 0 && t - i < 4) r[i*16 +: 16] = ma[i*4 + t - i];
    return r;
  endfunction

  function automatic logic [63:0] exp_n(int t);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 4; j++)
      if (t - j >= 0 && t - j < 4) r[j*16 +: 16] = mb[(t - j)*4 + j];
    return r;
  endfunction

  // Beats [from, to) from the model tile; gaps[b] inserts an idle cycle first.
  task automatic load_beats(input int from, input int to, input logic [15:0] gaps);
    for (int b = from; b < to; b++) begin
      int k;
      if (gaps[b]) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_a = ma[b];
      in_b = mb[b];
      k = 0;
      while (!in_ready && k < 20) begin
        @(posedge clk); #1;
        k++;
      end
      if (!in_ready) begin
        n_total++;
        $error("FAIL load_wait: observed in_ready 0 expected 1 within 20 cycles (beat %0d)", b);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Start from ARMED and follow the whole run; cycle 0 is the start cycle.
  task automatic stream_and_check(input string tag);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_clear_arr_rst"}, 64'(arr_rst_n), 64'd0);
    chk({tag, "_clear_busy"}, 64'(busy), 64'd1);
    chk({tag, "_clear_west"}, west_data, 64'd0);
    for (int t = 0; t < 10; t++) begin
      @(posedge clk); #1;
      cap_w[t] = west_data;
      cap_n[t] = north_data;
      if (t == 0) chk({tag, "_arr_rst_release"}, 64'(arr_rst_n), 64'd1);
      chk($sformatf("%s_west_t%0d", tag, t), west_data, exp_w(t));
      chk($sformatf("%s_north_t%0d", tag, t), north_data, exp_n(t));
    end
    for (int d = 0; d < 10; d++) begin
      @(posedge clk); #1;
      if (d == 0) chk({tag, "_drain_edges"}, west_data | north_data, 64'd0);
      if (d == 9) chk({tag, "_done_early"}, 64'(done), 64'd0);
    end
    @(posedge clk); #1;
    chk({tag, "_done_at_22"}, 64'(done), 64'd1);
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_ready_after_done"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; start = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_arr_rst_n", 64'(arr_rst_n), 64'd0);
    chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
    chk("rst_edges", west_data | north_data, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("load_ready", 64'(in_ready), 64'd1);

    // Identity A (Q8.8 one), B[r][c] = r*4+c.
    for (int k = 0; k < 16; k++) begin
      ma[k] = (k / 4 == k % 4) ? 16'h0100 : 16'h0000;
      mb[k] = 16'(k);
    end
    load_beats(0, 16, 16'h0000);
    chk("armed_ready", 64'(in_ready), 64'd0);
    stream_and_check("ident");
    chk("ident_t0_west", cap_w[0], 64'h0000_0000_0000_0100);
    chk("ident_t0_north", cap_n[0], 64'h0000_0000_0000_0000);
    chk("ident_t1_north", cap_n[1], 64'h0000_0000_0001_0004);
    chk("ident_t2_west", cap_w[2], 64'h0000_0000_0100_0000);
    chk("ident_t6_west", cap_w[6], 64'h0100_0000_0000_0000);
    chk("ident_t6_north", cap_n[6], 64'h000F_0000_0000_0000);
    chk("ident_t9_edges", cap_w[9] | cap_n[9], 64'd0);
    for (int k = 0; k < 16; k++)
      chk($sformatf("ident_pe%0d", k), 64'(acc[k/4][k%4]), 64'(k));

    // start during load is ignored; the load then resumes.
    for (int k = 0; k < 16; k++) begin
      ma[k] = 16'hA000 + 16'(k * 17);
      mb[k] = 16'hB000 + 16'(k * 5);
    end
    load_beats(0, 7, 16'h0000);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_in_load_ready", 64'(in_ready), 64'd1);
    chk("start_in_load_busy", 64'(busy), 64'd0);
    load_beats(7, 16, 16'h0000);
    chk("split_armed", 64'(in_ready), 64'd0);
    stream_and_check("split");

    // Idle cycles between beats do not disturb element order.
    for (int k = 0; k < 16; k++) begin
      ma[k] = 16'h1234 ^ 16'(k << 8);
      mb[k] = 16'hF00F - 16'(k * 3);
    end
    load_beats(0, 16, 16'b1001_0110_0010_1010);
    stream_and_check("gaps");

    // Reset in STREAM at t=5, then reload and restream.
    load_beats(0, 16, 16'h0000);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk); #1;
    chk("pre_reset_t5_west", west_data, exp_w(5));
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_edges", west_data | north_data, 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_status", {61'd0, busy, done, arr_rst_n}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_load_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 16; k++) begin
      ma[k] = 16'h0100;
      mb[k] = 16'h0200;
    end
    load_beats(0, 16, 16'h0000);
    stream_and_check("reload");
    for (int k = 0; k < 16; k++)
      chk($sformatf("pe_const%0d", k), 64'(acc[k/4][k%4]), 64'h0800);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
